// File: rtl/fixed_latency_stream_wrap.sv
// Valid/ready wrapper around a free-running fixed-latency core: credit-based admission,
// a valid/sideband tracking pipe that mirrors the core latency, and a show-ahead output FIFO.
module fixed_latency_stream_wrap #(
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned LANES      = 1,
  parameter int unsigned IN_W       = 21,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned SB_W       = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             snk_valid,
  output logic                             snk_ready,
  input  logic [LANES*IN_W-1:0]            snk_data,
  input  logic [SB_W-1:0]                  snk_sb,
  input  logic                             src_ready,
  output logic                             src_valid,
  output logic [LANES*OUT_W-1:0]           src_data,
  output logic [SB_W-1:0]                  src_sb,
  output logic [LANES*IN_W-1:0]            core_data,
  output logic                             core_in_valid,
  input  logic [LANES*OUT_W-1:0]           core_result,
  output logic                             core_clk_en,
  output logic                             core_rst,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  credits_used
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DW = LANES * OUT_W;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic          accept;
  logic          pop;
  logic          wr_en;
  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  logic [LATENCY-1:0] trk_vld_q;
  logic [SB_W-1:0]    trk_sb_q   [LATENCY];
  logic [DW-1:0]      mem_data_q [FIFO_DEPTH];
  logic [SB_W-1:0]    mem_sb_q   [FIFO_DEPTH];

  // Ready depends only on the credit register (and reset), never on src_ready.
  assign snk_ready     = !rst && (credits_q < DEPTH_C);
  assign accept        = snk_valid && snk_ready;
  assign src_valid     = (count_q != '0);
  assign pop           = src_valid && src_ready;
  assign wr_en         = trk_vld_q[LATENCY-1];

  assign core_data     = snk_data;
  assign core_in_valid = accept;
  assign core_clk_en   = 1'b1;
  assign core_rst      = rst;
  assign credits_used  = credits_q;

  assign src_data      = mem_data_q[rptr_q];
  assign src_sb        = mem_sb_q[rptr_q];

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q + CW'(1);
    end else if (!accept && pop) begin
      credits_d = credits_q - CW'(1);
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
    end
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      trk_vld_q <= '0;
    end else begin
      credits_q    <= credits_d;
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      trk_vld_q[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
      end
    end
  end

  // Sideband and payload storage carry no reset; they are only observed under a valid.
  always_ff @(posedge clk) begin
    trk_sb_q[0] <= snk_sb;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      trk_sb_q[i] <= trk_sb_q[i-1];
    end
    if (wr_en) begin
      mem_data_q[wptr_q] <= core_result;
      mem_sb_q[wptr_q]   <= trk_sb_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fixed_latency_stream_wrap.sv
// Scoreboard bench for fixed_latency_stream_wrap: 1-lane/depth-8 and 3-lane/depth-4 instances
// driven by directed and random traffic, each behind a 6-cycle delay-line core model.
module tb_fixed_latency_stream_wrap;
  localparam int L = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: LANES=1, FIFO_DEPTH=8
  logic        s_valid = 1'b0, s_ready, o_ready = 1'b0, o_valid;
  logic [20:0] s_data = '0, c_data;
  logic [1:0]  s_sb = '0, o_sb;
  logic [31:0] o_data, c_res;
  logic        c_iv, c_en, c_rst;
  logic [3:0]  cred;

  // Instance 1: LANES=3, FIFO_DEPTH=4
  logic        s_valid3 = 1'b0, s_ready3, o_ready3 = 1'b1, o_valid3;
  logic [62:0] s_data3 = '0, c_data3;
  logic [1:0]  s_sb3 = '0, o_sb3;
  logic [95:0] o_data3, c_res3;
  logic        c_iv3, c_en3, c_rst3;
  logic [2:0]  cred3;

  fixed_latency_stream_wrap #(
    .LATENCY(L), .LANES(1), .IN_W(21), .OUT_W(32), .SB_W(2), .FIFO_DEPTH(8)
  ) u0 (
    .clk(clk), .rst(rst),
    .snk_valid(s_valid), .snk_ready(s_ready), .snk_data(s_data), .snk_sb(s_sb),
    .src_ready(o_ready), .src_valid(o_valid), .src_data(o_data), .src_sb(o_sb),
    .core_data(c_data), .core_in_valid(c_iv), .core_result(c_res),
    .core_clk_en(c_en), .core_rst(c_rst), .credits_used(cred)
  );

  fixed_latency_stream_wrap #(
    .LATENCY(L), .LANES(3), .IN_W(21), .OUT_W(32), .SB_W(2), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst),
    .snk_valid(s_valid3), .snk_ready(s_ready3), .snk_data(s_data3), .snk_sb(s_sb3),
    .src_ready(o_ready3), .src_valid(o_valid3), .src_data(o_data3), .src_sb(o_sb3),
    .core_data(c_data3), .core_in_valid(c_iv3), .core_result(c_res3),
    .core_clk_en(c_en3), .core_rst(c_rst3), .credits_used(cred3)
  );

  // Core models: plain L-cycle delay lines, zero-extending each lane to 32 bits.
  logic [20:0] p0 [L];
  logic [62:0] p3 [L];
  always @(posedge clk) begin
    p0[0] <= c_data;
    p3[0] <= c_data3;
    for (int i = 1; i < L; i++) begin
      p0[i] <= p0[i-1];
      p3[i] <= p3[i-1];
    end
  end
  assign c_res = {11'h0, p0[L-1]};
  always_comb begin
    c_res3 = '0;
    for (int j = 0; j < 3; j++) c_res3[j*32 +: 32] = {11'h0, p3[L-1][j*21 +: 21]};
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / monitor for instance 0
  logic [33:0] q0 [$];
  logic [33:0] e0, hd0;
  logic        hold0 = 1'b0, rst_seen0 = 1'b0, exp_rdy0;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_snk_ready", s_ready, 1'b0);
      check("rst_core_rst", c_rst, 1'b1);
      q0.delete();
      hold0 = 1'b0;
      rst_seen0 = 1'b1;
    end else begin
      if (rst_seen0) begin
        check("post_rst_src_valid", o_valid, 1'b0);
        check("post_rst_snk_ready", s_ready, 1'b1);
        rst_seen0 = 1'b0;
      end
      exp_rdy0 = (q0.size() < 8);
      check("credits", cred, q0.size());
      check("credits_max", cred <= 4'd8, 1'b1);
      check("snk_ready", s_ready, exp_rdy0);
      check("core_if", {c_data, c_iv, c_en, c_rst}, {s_data, s_valid & exp_rdy0, 1'b1, 1'b0});
      if (hold0) begin
        check("hold_valid", o_valid, 1'b1);
        check("hold_stable", {o_data, o_sb}, hd0);
      end
      if (o_valid && o_ready) begin
        if (q0.size() == 0) check("unexpected_beat", o_valid, 1'b0);
        else begin
          e0 = q0.pop_front();
          check("data", o_data, e0[33:2]);
          check("sb", o_sb, e0[1:0]);
        end
      end
      if (s_valid && s_ready) q0.push_back({{11'h0, s_data}, s_sb});
      hold0 = o_valid && !o_ready;
      hd0 = {o_data, o_sb};
    end
  end

  // Scoreboard / monitor for instance 1
  logic [97:0] q3 [$];
  logic [97:0] e3;
  logic [95:0] ex3;
  logic        first3 = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
    end else begin
      check("l3_credits", cred3, q3.size());
      if (o_valid3 && o_ready3) begin
        if (q3.size() == 0) check("l3_unexpected_beat", o_valid3, 1'b0);
        else begin
          e3 = q3.pop_front();
          check("l3_data", o_data3, e3[97:2]);
          check("l3_sb", o_sb3, e3[1:0]);
          if (first3) check("l3_lane_order", o_data3, {32'd3, 32'd2, 32'd1});
          first3 = 1'b0;
        end
      end
      if (s_valid3 && s_ready3) begin
        for (int j = 0; j < 3; j++) ex3[j*32 +: 32] = {11'h0, s_data3[j*21 +: 21]};
        q3.push_back({ex3, s_sb3});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, nvalid, first, last, nxt, cyc, n3, win;

    // Reset
    step(); step();
    @(negedge clk);
    check("reset_src_valid", o_valid, 1'b0);
    check("reset_credits", cred, 4'd0);
    step();
    rst = 1'b0;

    // Single beat at cycle 0: visible at cycle L+1, credit held through that cycle
    step();
    s_valid = 1'b1; s_data = 21'h1ABCD; s_sb = 2'b01; o_ready = 1'b1;
    @(negedge clk);
    check("single_accept", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      check("single_valid_timing", o_valid, (k == L + 1));
      check("single_credits", cred, (k <= L + 1) ? 4'd1 : 4'd0);
      if (k == L + 1) check("single_result", {o_data, o_sb}, {32'h0001ABCD, 2'b01});
      step();
    end

    // Streaming 100 beats
    nvalid = 0; first = -1; last = -1;
    for (int i = 0; i < 120; i++) begin
      if (i < 100) begin s_valid = 1'b1; s_data = 21'(i); s_sb = 2'(i); end
      else s_valid = 1'b0;
      @(negedge clk);
      if (i < 100) check("stream_ready", s_ready, 1'b1);
      if (o_valid) begin
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
      step();
    end
    check("stream_count", nvalid, 100);
    check("stream_contiguous", last - first + 1, 100);

    // Backpressure: exactly FIFO_DEPTH beats admitted while src_ready is low
    o_ready = 1'b0; nacc = 0;
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1; s_data = 21'(32'h100 + i); s_sb = 2'(i);
      @(negedge clk);
      if (s_ready) nacc++;
      step();
    end
    check("bp_accepted", nacc, 8);
    s_data = 21'h200; o_ready = 1'b1;
    @(negedge clk);
    check("bp_full_ready", s_ready, 1'b0);
    check("bp_full_credits", cred, 4'd8);
    step();
    o_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_return", s_ready, 1'b1);
    step();
    @(negedge clk);
    check("bp_full_again", s_ready, 1'b0);
    step();
    s_valid = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < 25; i++) step();
    @(negedge clk);
    check("bp_drained_valid", o_valid, 1'b0);
    check("bp_drained_queue", q0.size(), 0);
    step();

    // Reset with 4 buffered and 3 in flight
    o_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 21'(32'h300 + i); s_sb = 2'(i);
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 21'(32'h310 + i); s_sb = 2'(i);
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_credits", cred, 4'd7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("no_stale_beat", o_valid, 1'b0);
      step();
    end
    s_valid = 1'b1; s_data = 21'h5; s_sb = 2'b10;
    @(negedge clk);
    check("post_rst_accept", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      check("post_rst_latency", o_valid, (k == L + 1));
      if (k == L + 1) check("post_rst_result", {o_data, o_sb}, {32'h5, 2'b10});
      step();
    end

    // Random valid/ready, 10k beats
    nxt = 0; nacc = 0; cyc = 0;
    while (nacc < 10000 && cyc < 60000) begin
      s_valid = 1'($urandom); s_data = 21'(nxt); s_sb = 2'($urandom); o_ready = 1'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) begin nacc++; nxt++; end
      step();
      cyc++;
    end
    check("random_accepted", nacc, 10000);
    s_valid = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    @(negedge clk);
    check("random_drained_valid", o_valid, 1'b0);
    check("random_drained_queue", q0.size(), 0);
    step();

    // Three lanes, depth 4: throughput 4 beats per 8 cycles
    n3 = 0; win = 0;
    for (int i = 0; i < 48; i++) begin
      s_valid3 = 1'b1;
      s_data3 = {21'(3*n3 + 3), 21'(3*n3 + 2), 21'(3*n3 + 1)};
      s_sb3 = 2'(n3);
      @(negedge clk);
      if (s_ready3) begin
        n3++;
        if (i >= 16) win++;
      end
      step();
    end
    check("l3_throughput", win, 16);
    s_valid3 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    @(negedge clk);
    check("l3_drained_valid", o_valid3, 1'b0);
    check("l3_drained_queue", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
